// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  // Defaults for the controller parameters.
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hDEAD_BEEF;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // One buffered fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. A synchronous flush empties it and
// takes priority over any push or pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A pop on an empty FIFO is ignored; a push into a full FIFO is accepted
  // only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH
  // is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  // NOTE: the storage array is deliberately not reset; occupancy is tracked
  // by count, and stale slots are never presented because the head is masked
  // while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, reads the combinational
// instruction memory, buffers fetched words and hands them to decode over a
// valid/ready handshake. Redirects flush and refetch; the end-of-program
// marker word halts fetching.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_raddr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_next;

  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         fifo_full;
  logic         fifo_empty;

  logic         handshake;
  logic         pop;
  logic         push_ok;
  logic         is_halt_word;
  logic         push;
  logic         halt_hit;

  assign imem_raddr = pc;

  // The handshake is judged on the registered head only; a redirect discards
  // the head instead of delivering it.
  assign handshake    = out_valid & out_ready;
  assign pop          = handshake & ~redirect_valid;
  assign push_ok      = (state == ST_RUN) & fetch_en & (~fifo_full | handshake);
  assign is_halt_word = (imem_rdata == HALT_WORD);
  assign push         = push_ok & ~is_halt_word & ~redirect_valid;
  assign halt_hit     = push_ok & is_halt_word & ~redirect_valid;

  assign push_entry.pc    = pc;
  assign push_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Decode-facing outputs come straight from FIFO registers and read as zero
  // whenever nothing is buffered.
  assign out_valid = ~fifo_empty;
  assign out_instr = fifo_empty ? 32'h0 : head.instr;
  assign out_pc    = fifo_empty ? 32'h0 : head.pc;
  assign halted    = (state == ST_HALT);

  // Next-state logic: redirect dominates, then the normal IDLE/RUN/HALT walk.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = (state == ST_IDLE) ? ST_IDLE : ST_RUN;
    end else begin
      case (state)
        ST_IDLE: if (fetch_en) state_next = ST_RUN;
        ST_RUN:  if (halt_hit) state_next = ST_HALT;
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Next PC: redirect target, sequential advance on a push, otherwise hold
  // (including on the halt word, so the PC rests on the marker address).
  always_comb begin
    pc_next = pc;
    if (redirect_valid) pc_next = word_align(redirect_pc);
    else if (push)      pc_next = pc + 32'd4;
  end

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with a small program ROM model.
module tb_fetch_ctrl;

  localparam logic [31:0] I0 = 32'h0000_0013;
  localparam logic [31:0] I1 = 32'h0010_0093;
  localparam logic [31:0] I2 = 32'h0020_8133;
  localparam logic [31:0] HW = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        fen;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] eraddr;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        eh;
  } vec_t;

  vec_t vecs[$];

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .imem_raddr    (imem_raddr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Program ROM: three instructions then the end marker; everything else
  // reads as a nop.
  always_comb begin
    case (imem_raddr)
      32'h0:   imem_rdata = I0;
      32'h4:   imem_rdata = I1;
      32'h8:   imem_rdata = I2;
      32'hC:   imem_rdata = HW;
      default: imem_rdata = I0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic void add(input logic fen, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic ev,
                              input logic [31:0] eraddr, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic eh);
    vec_t v;
    v.fen = fen; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev;
    v.eraddr = eraddr; v.epc = epc; v.einstr = einstr; v.eh = eh;
    vecs.push_back(v);
  endfunction

  // Each vector: at the falling edge compare the registered outputs expected
  // in this cycle, then drive the inputs that act on the next rising edge.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d] valid", tag, i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
      check($sformatf("%s[%0d] halted", tag, i), {31'b0, halted}, {31'b0, vecs[i].eh});
      check($sformatf("%s[%0d] raddr", tag, i), imem_raddr, vecs[i].eraddr);
      check($sformatf("%s[%0d] out_pc", tag, i), out_pc, vecs[i].epc);
      check($sformatf("%s[%0d] out_instr", tag, i), out_instr, vecs[i].einstr);
      fetch_en       = vecs[i].fen;
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
    end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", {31'b0, out_valid}, 32'd0);
    check("reset halted", {31'b0, halted}, 32'd0);
    check("reset raddr", imem_raddr, 32'h0);
    check("reset out_pc", out_pc, 32'h0);
    check("reset out_instr", out_instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //   fen   rdy   rv    rpc            ev    raddr          pc             instr eh
    // Straight run to the marker.
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'h0,         I0,    1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h4,         I1,    1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         32'h8,         I2,    1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'hC,         32'h0,         32'h0, 1'b1);
    // Redirect out of HALT to 0, then stall decode for five cycles.
    add(1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 32'hC,         32'h0,         32'h0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         32'h0,         I0,    1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'h0,         I0,    1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'h0,         I0,    1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'h0,         I0,    1'b0);
    // Release: full-with-pop pushes the third word, then drain while halted.
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h0,         I0,    1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         32'h4,         I1,    1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         32'h8,         I2,    1'b1);
    // Refill two entries, then redirect to unaligned 0x5 discarding both.
    add(1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 32'hC,         32'h0,         32'h0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         32'h0,         I0,    1'b0);
    add(1'b1, 1'b1, 1'b1, 32'h5,         1'b1, 32'h8,         32'h0,         I0,    1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h4,         32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h4,         I1,    1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         32'h8,         I2,    1'b0);
    // Redirect to the top word: PC wraps to 0.
    add(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hC,         32'h0,         32'h0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'hFFFF_FFFC, I0,    1'b0);
    // fetch_en low in RUN: PC holds, buffered word still drains.
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'h0,         I0,    1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h4,         32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4,         32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'h4,         I1,    1'b0);
    // Full without pop: marker at 0xC is not fetched, so no halt.
    add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         32'h4,         I1,    1'b0);
    run_vecs("run");

    // Reset mid-stream with two entries buffered: outputs clear immediately.
    @(negedge clk);
    check("pre-rst valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst valid", {31'b0, out_valid}, 32'd0);
    check("rst halted", {31'b0, halted}, 32'd0);
    check("rst raddr", imem_raddr, 32'h0);
    check("rst out_pc", out_pc, 32'h0);
    fetch_en = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("idle[%0d] valid", i), {31'b0, out_valid}, 32'd0);
      check($sformatf("idle[%0d] raddr", i), imem_raddr, 32'h0);
    end

    // Restart from RESET_PC; redirect coincident with the marker wins.
    vecs.delete();
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'h0,         I0,    1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h4,         I1,    1'b0);
    add(1'b1, 1'b1, 1'b1, 32'h4,         1'b1, 32'hC,         32'h8,         I2,    1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h4,         32'h0,         32'h0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h4,         I1,    1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         32'h8,         I2,    1'b0);
    run_vecs("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
